// File: rtl/ex_muldiv_ctrl.sv
// Iterative unsigned mul/mulhu/divu/remu sequencer beside the EX stage (32 iterations).
// Optional `MULDIV_FASTPATH_EN: zero-operand ops skip the iteration loop.
module ex_muldiv_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      ALUop_i,
    input  logic [XLEN-1:0] Oprend1,
    input  logic [XLEN-1:0] Oprend2,
    input  logic [4:0]      WriteDataNum_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            WriteReg_o,
    output logic [4:0]      WriteDataNum_o,
    output logic [XLEN-1:0] WriteData_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt, w_cnt_n;
    logic [1:0]        r_op, w_op_n;
    logic [XLEN-1:0]   r_opa, w_opa_n;
    logic [XLEN-1:0]   r_hi, w_hi_n;
    logic [XLEN-1:0]   r_lo, w_lo_n;
    logic [4:0]        r_wnum, w_wnum_n;
    logic [4:0]        r_wnum_o, w_wnum_o_n;
    logic [XLEN-1:0]   r_wdata, w_wdata_n;

    logic              w_is_md, w_accept;
    logic [XLEN:0]     w_msum, w_rsh, w_rdiff;
    logic              w_rge;
    logic [XLEN-1:0]   w_hi_it, w_lo_it;

    assign w_is_md  = (ALUop_i[4:3] == 2'b11) && !ALUop_i[2];
    assign w_accept = valid_i && w_is_md && !flush_i;

    // r_op[1] selects divide; r_op[0] selects the high half (mulhu) or remainder (remu).
    assign w_msum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : '0);
    assign w_rsh   = {r_hi, r_lo[XLEN-1]};
    assign w_rge   = w_rsh >= {1'b0, r_opa};
    assign w_rdiff = w_rsh - {1'b0, r_opa};

    always_comb begin
        if (r_op[1]) begin
            w_hi_it = w_rge ? w_rdiff[XLEN-1:0] : w_rsh[XLEN-1:0];
            w_lo_it = {r_lo[XLEN-2:0], w_rge};
        end else begin
            w_hi_it = w_msum[XLEN:1];
            w_lo_it = {w_msum[0], r_lo[XLEN-1:1]};
        end
    end

`ifdef MULDIV_FASTPATH_EN
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    assign w_fast     = (Oprend2 == '0) || ((Oprend1 == '0) && !ALUop_i[1]);
    assign w_fast_res = !ALUop_i[1] ? '0 : (ALUop_i[0] ? Oprend1 : '1);
`endif

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_op_n     = r_op;
        w_opa_n    = r_opa;
        w_hi_n     = r_hi;
        w_lo_n     = r_lo;
        w_wnum_n   = r_wnum;
        w_wnum_o_n = r_wnum_o;
        w_wdata_n  = r_wdata;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_op_n    = ALUop_i[1:0];
                    w_opa_n   = ALUop_i[1] ? Oprend2 : Oprend1;
                    w_lo_n    = ALUop_i[1] ? Oprend1 : Oprend2;
                    w_hi_n    = '0;
                    w_wnum_n  = WriteDataNum_i;
                    w_cnt_n   = '0;
                    w_state_n = StBusy;
`ifdef MULDIV_FASTPATH_EN
                    if (w_fast) begin
                        w_state_n  = StDone;
                        w_wdata_n  = w_fast_res;
                        w_wnum_o_n = WriteDataNum_i;
                    end
`endif
                end
            end
            StBusy: begin
                if (flush_i) begin
                    w_state_n = StIdle;
                    w_cnt_n   = '0;
                end else begin
                    w_hi_n  = w_hi_it;
                    w_lo_n  = w_lo_it;
                    w_cnt_n = r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        w_state_n  = StDone;
                        w_wdata_n  = r_op[0] ? w_hi_it : w_lo_it;
                        w_wnum_o_n = r_wnum;
                    end
                end
            end
            StDone:  w_state_n = StIdle;
            default: w_state_n = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_op     <= '0;
            r_opa    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_wnum   <= '0;
            r_wnum_o <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_op     <= w_op_n;
            r_opa    <= w_opa_n;
            r_hi     <= w_hi_n;
            r_lo     <= w_lo_n;
            r_wnum   <= w_wnum_n;
            r_wnum_o <= w_wnum_o_n;
            r_wdata  <= w_wdata_n;
        end
    end

    assign stall_o        = (r_state == StIdle && w_accept) || (r_state == StBusy);
    assign busy_o         = (r_state == StBusy);
    assign done_o         = (r_state == StDone) && !flush_i;
    assign WriteReg_o     = done_o;
    assign WriteDataNum_o = r_wnum_o;
    assign WriteData_o    = r_wdata;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl; honours `MULDIV_FASTPATH_EN for latency.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  ALUop_i;
    logic [31:0] Oprend1;
    logic [31:0] Oprend2;
    logic [4:0]  WriteDataNum_i;
    logic        flush_i;
    logic        stall_o, busy_o, done_o, WriteReg_o;
    logic [4:0]  WriteDataNum_o;
    logic [31:0] WriteData_o;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [4:0] OpMul   = 5'b11000;
    localparam logic [4:0] OpMulhu = 5'b11001;
    localparam logic [4:0] OpDivu  = 5'b11010;
    localparam logic [4:0] OpRemu  = 5'b11011;

`ifdef MULDIV_FASTPATH_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 33;
`endif

    ex_muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid_i),
        .ALUop_i        (ALUop_i),
        .Oprend1        (Oprend1),
        .Oprend2        (Oprend2),
        .WriteDataNum_i (WriteDataNum_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .WriteReg_o     (WriteReg_o),
        .WriteDataNum_o (WriteDataNum_o),
        .WriteData_o    (WriteData_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue at a negedge, then watch negedges until done_o (bounded); lat counts cycles after issue.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] num, output int lat, output int stalls,
                          output logic [31:0] data, output logic [4:0] wnum);
        @(negedge clk);
        valid_i = 1'b1; ALUop_i = op; Oprend1 = a; Oprend2 = b; WriteDataNum_i = num;
        #1;
        check_eq("issue_stall", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        valid_i = 1'b0; Oprend1 = 32'hDEAD_BEEF; Oprend2 = 32'h1234_5678; WriteDataNum_i = 5'd31;
        lat = 1;
        stalls = 0;
        while (!done_o && lat < 40) begin
            if (stall_o) stalls++;
            @(negedge clk);
            lat++;
        end
        data = WriteData_o;
        wnum = WriteDataNum_o;
        check_eq("done_seen", {31'd0, done_o}, 32'd1);
        check_eq("wreg_eq_done", {31'd0, WriteReg_o}, 32'd1);
        check_eq("done_stall", {31'd0, stall_o}, 32'd0);
    endtask

    int          lat, stalls;
    logic [31:0] data;
    logic [4:0]  wnum;
    int          seen;

    initial begin
        rst = 1'b0; valid_i = 1'b0; ALUop_i = '0; Oprend1 = '0; Oprend2 = '0;
        WriteDataNum_i = '0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_data", WriteData_o, 32'd0);
        check_eq("rst_wnum", {27'd0, WriteDataNum_o}, 32'd0);
        rst = 1'b1;

        // Not an M op (bit 2 set): must not stall or start.
        @(negedge clk);
        valid_i = 1'b1; ALUop_i = 5'b11100; Oprend1 = 32'd5; Oprend2 = 32'd5;
        #1;
        check_eq("nonmd_stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0;
        check_eq("nonmd_busy", {31'd0, busy_o}, 32'd0);

        run_op(OpMul, 32'd7, 32'd6, 5'd5, lat, stalls, data, wnum);
        check_eq("mul_lat", lat, 33);
        check_eq("mul_stalls", stalls, 32);
        check_eq("mul_data", data, 32'd42);
        check_eq("mul_wnum", {27'd0, wnum}, 32'd5);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done_o}, 32'd0);
        check_eq("data_hold", WriteData_o, 32'd42);

        run_op(OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, lat, stalls, data, wnum);
        check_eq("mulhu_data", data, 32'hFFFF_FFFE);
        check_eq("mulhu_wnum", {27'd0, wnum}, 32'd9);
        run_op(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, lat, stalls, data, wnum);
        check_eq("mul_ff_data", data, 32'h0000_0001);

        // Back-to-back: second op driven in the cycle right after DONE.
        run_op(OpDivu, 32'd100, 32'd7, 5'd3, lat, stalls, data, wnum);
        check_eq("divu_data", data, 32'd14);
        run_op(OpRemu, 32'd100, 32'd7, 5'd4, lat, stalls, data, wnum);
        check_eq("remu_lat", lat, 33);
        check_eq("remu_data", data, 32'd2);
        check_eq("remu_wnum", {27'd0, wnum}, 32'd4);

        run_op(OpDivu, 32'd1234, 32'd0, 5'd6, lat, stalls, data, wnum);
        check_eq("divz_lat", lat, ZeroLat);
        check_eq("divz_data", data, 32'hFFFF_FFFF);
        run_op(OpRemu, 32'd1234, 32'd0, 5'd7, lat, stalls, data, wnum);
        check_eq("remz_lat", lat, ZeroLat);
        check_eq("remz_data", data, 32'd1234);
        run_op(OpMulhu, 32'd0, 32'd77, 5'd8, lat, stalls, data, wnum);
        check_eq("mulz_lat", lat, ZeroLat);
        check_eq("mulz_data", data, 32'd0);

        // Flush on the 10th BUSY cycle.
        @(negedge clk);
        valid_i = 1'b1; ALUop_i = OpMul; Oprend1 = 32'd1000; Oprend2 = 32'd1000;
        WriteDataNum_i = 5'd12;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
        check_eq("pre_flush_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("flush_busy", {31'd0, busy_o}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        check_eq("flush_no_done", seen, 0);
        run_op(OpMul, 32'd3, 32'd3, 5'd13, lat, stalls, data, wnum);
        check_eq("post_flush_data", data, 32'd9);
        check_eq("post_flush_wnum", {27'd0, wnum}, 32'd13);

        // Reset on the 20th BUSY cycle.
        @(negedge clk);
        valid_i = 1'b1; ALUop_i = OpDivu; Oprend1 = 32'd500; Oprend2 = 32'd3;
        WriteDataNum_i = 5'd14;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        check_eq("mid_rst_data", WriteData_o, 32'd0);
        check_eq("mid_rst_wnum", {27'd0, WriteDataNum_o}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) seen++;
            @(negedge clk);
        end
        check_eq("rst_no_done", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
